// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
//   Shared definitions for the cache-line compressor datapath.
//   - state_t     : length-tracker FSM states (ACC, FLUSH, DONE)
//   - len_width   : width of a per-word compressed length (0..WORD_BITS)
//   - line_width  : width of a running line bit count (0..LINE_BITS)
//   - idx_width   : width of an output-word index, never less than 1
//   - DEF_LINE_BITS / DEF_WORD_BITS : default geometry, shared with the packer
// -----------------------------------------------------------------------------
package cmp_pkg;

  localparam int DEF_LINE_BITS = 128;
  localparam int DEF_WORD_BITS = 64;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int len_width(input int word_bits);
    return $clog2(word_bits) + 1;
  endfunction

  function automatic int line_width(input int line_bits);
    return $clog2(line_bits) + 1;
  endfunction

  function automatic int idx_width(input int line_bits, input int word_bits);
    int w;
    w = $clog2(line_bits / word_bits);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cmp_length_tracker.sv
// -----------------------------------------------------------------------------
// cmp_length_tracker
//   Running bit-length tracker between the per-word compressor and the packing
//   register array. One compressed-word length is accepted per beat; the block
//   keeps the line total, the fill level of the current output word and the
//   output word count, and reports word completion, end-of-line padding and
//   whether the line fit inside LINE_BITS.
//
// Handshake: a beat (i_len, i_last) transfers on a rising i_clk edge where
//   i_valid && o_ready. o_ready is a registered signal, high only in ACC (and
//   low throughout reset and on the first cycle out of it); i_valid while
//   o_ready is low is simply not consumed. i_ack is taken only while o_done is
//   visible and is ignored at any other time.
//
// Ports
//   i_clk, i_reset      clock; asynchronous active-low reset
//   i_valid, o_ready    beat handshake
//   i_len, i_last       compressed length of this word; last word of the line
//   i_ack               consumer took the line result
//   o_store, o_word_idx pulse: output word o_word_idx just filled
//   o_shift_amount      bits already occupying the current output word
//   o_fill, o_pad_bits  pulse: pad the partial last word by o_pad_bits
//   o_stop              pulse: line overflowed LINE_BITS
//   o_done              line result available
//   o_compressed        with o_done: 1 = line fit, 0 = store uncompressed
//   o_line_bits         accumulated bits of the line
//   o_state             current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module cmp_length_tracker
  import cmp_pkg::*;
#(
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int LEN_W     = len_width(WORD_BITS)
) (
  input  logic                                         i_clk,
  input  logic                                         i_reset,
  input  logic                                         i_valid,
  output logic                                         o_ready,
  input  logic [LEN_W-1:0]                             i_len,
  input  logic                                         i_last,
  input  logic                                         i_ack,
  output logic                                         o_store,
  output logic [idx_width(LINE_BITS, WORD_BITS)-1:0]   o_word_idx,
  output logic [LEN_W-1:0]                             o_shift_amount,
  output logic                                         o_fill,
  output logic [LEN_W-1:0]                             o_pad_bits,
  output logic                                         o_stop,
  output logic                                         o_done,
  output logic                                         o_compressed,
  output logic [line_width(LINE_BITS)-1:0]             o_line_bits,
  output logic [1:0]                                   o_state
);

  localparam int LB_W  = line_width(LINE_BITS);
  localparam int IDX_W = idx_width(LINE_BITS, WORD_BITS);
  // One extra bit on each sum so an overflowing beat is seen, not wrapped.
  localparam int TOT_W = LB_W + 1;
  localparam int FIL_W = LEN_W + 1;

  localparam logic [TOT_W-1:0] LINE_LIM = TOT_W'(LINE_BITS);
  localparam logic [FIL_W-1:0] WORD_LIM = FIL_W'(WORD_BITS);

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [LB_W-1:0]    line_q,  line_d;
  logic [LEN_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   cnt_q,   cnt_d;
  logic               store_q, store_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               fill_q,  fill_d;
  logic [LEN_W-1:0]   pad_q,   pad_d;
  logic               stop_q,  stop_d;
  logic               done_q,  done_d;
  logic               comp_q,  comp_d;

  logic [TOT_W-1:0]   tot_n;
  logic [FIL_W-1:0]   fil_n;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    store_d = 1'b0;
    idx_d   = idx_q;
    fill_d  = 1'b0;
    pad_d   = pad_q;
    stop_d  = 1'b0;
    done_d  = 1'b0;
    comp_d  = comp_q;
    tot_n   = {1'b0, line_q} + TOT_W'(i_len);
    fil_n   = {1'b0, shift_q} + {1'b0, i_len};

    unique case (state_q)
      ACC: begin
        if (i_valid && ready_q) begin
          if (tot_n > LINE_LIM) begin
            // Overflow: counters freeze at their pre-beat values so the
            // consumer sees how far the line got before it stopped fitting.
            stop_d  = 1'b1;
            comp_d  = 1'b0;
            state_d = DONE;
          end else begin
            line_d = tot_n[LB_W-1:0];
            if (fil_n >= WORD_LIM) begin
              store_d = 1'b1;
              idx_d   = cnt_q;
              cnt_d   = cnt_q + IDX_W'(1);
              shift_d = LEN_W'(fil_n - WORD_LIM);
            end else begin
              shift_d = fil_n[LEN_W-1:0];
            end
            // A line ending exactly on a word boundary has nothing to pad.
            if (i_last || (tot_n == LINE_LIM)) begin
              if (shift_d != '0) begin
                state_d = FLUSH;
              end else begin
                state_d = DONE;
                comp_d  = 1'b1;
              end
            end
          end
        end
      end

      FLUSH: begin
        fill_d  = 1'b1;
        pad_d   = LEN_W'(WORD_LIM - {1'b0, shift_q});
        comp_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        done_d = 1'b1;
        // Only acknowledge once o_done has actually been presented.
        if (i_ack && done_q) begin
          done_d  = 1'b0;
          comp_d  = 1'b0;
          line_d  = '0;
          shift_d = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end

      default: begin
        state_d = ACC;
      end
    endcase

    ready_d = (state_d == ACC);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ACC;
      ready_q <= 1'b0;
      line_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      store_q <= 1'b0;
      idx_q   <= '0;
      fill_q  <= 1'b0;
      pad_q   <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      comp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      line_q  <= line_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      pad_q   <= pad_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      comp_q  <= comp_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_store        = store_q;
  assign o_word_idx     = idx_q;
  assign o_shift_amount = shift_q;
  assign o_fill         = fill_q;
  assign o_pad_bits     = pad_q;
  assign o_stop         = stop_q;
  assign o_done         = done_q;
  assign o_compressed   = comp_q;
  assign o_line_bits    = line_q;
  assign o_state        = state_q;

endmodule
